// File: rtl/elastic_pipe_reg.sv
// Elastic N-stage pipeline register with a valid/ready handshake on both ends.
// An empty stage always loads, so bubbles close up while the output is blocked.
module elastic_pipe_reg #(
  parameter int               WIDTH       = 32,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         stall,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d     [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_d [STAGES];

  // A stage advances when it is empty or the stage ahead of it advances.
  always_comb begin : ready_chain
    logic chain;
    chain = out_ready;
    adv   = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain  = !v[i] || chain;
      adv[i] = chain;
    end
  end

  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= RESET_VALUE;
    end else if (flush) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= RESET_VALUE;
    end else if (!stall) begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) begin
          v[i] <= src_v[i];
          if (src_v[i]) d[i] <= src_d[i];
        end
      end
    end
  end

  // During flush the input is swallowed so upstream never waits on a dead pipe.
  assign in_ready  = reset && (flush || (!stall && adv[0]));
  assign out_valid = v[STAGES-1] && !flush && !stall;
  assign out_data  = d[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + OCC_W'(v[i]);
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg (STAGES=3, WIDTH=8): directed scenarios plus a
// randomized run scored against a queue-of-payloads reference model.
module tb_elastic_pipe_reg;

  localparam int         STAGES = 3;
  localparam int         WIDTH  = 8;
  localparam logic [7:0] RV     = 8'h5A;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       stall;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [1:0] occupancy;

  int checks   = 0;
  int failures = 0;

  // Reference model: payloads oldest-first with their stage positions.
  int         mpos [$];
  logic [7:0] mdat [$];

  elastic_pipe_reg #(.WIDTH(WIDTH), .STAGES(STAGES), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic fl, input logic st);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    stall     = st;
    #1;
  endtask

  task automatic clear();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
      checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
      checks++; if (out_data !== RV) begin failures++; $display("FAIL rst_out_data got=%h exp=%h", out_data, RV); end
    end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; stall = 1'b0; out_ready = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready got=%0b exp=1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL rel_occupancy got=%0d exp=0", occupancy); end
  endtask

  task automatic test_streaming();
    logic [7:0] got [$];
    int first_v, last_v, peak;
    first_v = -1; last_v = -1; peak = 0;
    clear();
    for (int c = 0; c < 8; c++) begin
      drive(c < 3, (c == 0) ? 8'h11 : (c == 1) ? 8'h22 : 8'h33, 1'b1, 1'b0, 1'b0);
      if (out_valid === 1'b1) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        got.push_back(out_data);
      end
      if (int'(occupancy) > peak) peak = int'(occupancy);
    end
    checks++; if (first_v != 3) begin failures++; $display("FAIL stream_latency got=%0d exp=3", first_v); end
    checks++; if (last_v != 5) begin failures++; $display("FAIL stream_last got=%0d exp=5", last_v); end
    checks++; if (peak != 3) begin failures++; $display("FAIL stream_peak_occ got=%0d exp=3", peak); end
    checks++;
    if (got.size() != 3) begin failures++; $display("FAIL stream_count got=%0d exp=3", got.size()); end
    else if (got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
      failures++; $display("FAIL stream_order got=%h %h %h exp=11 22 33", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a [4];
    logic [7:0] got [$];
    int k;
    a[0] = 8'hA1; a[1] = 8'hA2; a[2] = 8'hA3; a[3] = 8'hA4;
    k = 0;
    clear();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, a[k], 1'b0, 1'b0, 1'b0);
      if (in_ready === 1'b1 && k < 3) k++;
    end
    checks++; if (k != 3) begin failures++; $display("FAIL bp_accepted got=%0d exp=3", k); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%0b exp=0", in_ready); end
    checks++; if (occupancy !== 2'd3) begin failures++; $display("FAIL bp_full_occ got=%0d exp=3", occupancy); end
    drive(1'b1, a[3], 1'b1, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_chain_ready got=%0b exp=1", in_ready); end
    if (out_valid === 1'b1) got.push_back(out_data);
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (out_valid === 1'b1) got.push_back(out_data);
    end
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    else if (got[0] !== 8'hA1 || got[1] !== 8'hA2 || got[2] !== 8'hA3 || got[3] !== 8'hA4) begin
      failures++; $display("FAIL bp_order got=%h %h %h %h exp=a1 a2 a3 a4", got[0], got[1], got[2], got[3]);
    end
  endtask

  task automatic test_bubble();
    logic [7:0] got [$];
    logic all_ready;
    all_ready = 1'b1;
    clear();
    drive(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0); all_ready &= in_ready;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); all_ready &= in_ready;
    drive(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0); all_ready &= in_ready;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); all_ready &= in_ready;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); all_ready &= in_ready;
    checks++; if (all_ready !== 1'b1) begin failures++; $display("FAIL bub_ready_hold got=%0b exp=1", all_ready); end
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bub_occ got=%0d exp=2", occupancy); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hB1) begin
      failures++; $display("FAIL bub_head got=%0b/%h exp=1/b1", out_valid, out_data);
    end
    drive(1'b1, 8'hB3, 1'b0, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bub_third_ready got=%0b exp=1", in_ready); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd3 || in_ready !== 1'b0) begin
      failures++; $display("FAIL bub_full got=%0d/%0b exp=3/0", occupancy, in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (out_valid === 1'b1) got.push_back(out_data);
    end
    checks++;
    if (got.size() != 3) begin failures++; $display("FAIL bub_count got=%0d exp=3", got.size()); end
    else if (got[0] !== 8'hB1 || got[1] !== 8'hB2 || got[2] !== 8'hB3) begin
      failures++; $display("FAIL bub_order got=%h %h %h exp=b1 b2 b3", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    clear();
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fl_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_out_valid got=%0b exp=0", out_valid); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL fl_occ got=%0d exp=0", occupancy); end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL fl_dropped got=%0d exp=0", seen); end
  endtask

  task automatic test_stall_reset();
    clear();
    drive(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL st_in_ready got=%0b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL st_out_valid got=%0b exp=0", out_valid); end
      checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL st_occ got=%0d exp=2", occupancy); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hC1 || occupancy !== 2'd2) begin
      failures++; $display("FAIL st_kept got=%0b/%h/%0d exp=1/c1/2", out_valid, out_data, occupancy);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid got=%0b exp=0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL ar_occ got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ar_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_data !== RV) begin failures++; $display("FAIL ar_out_data got=%h exp=%h", out_data, RV); end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL ar_after got=%0d/%0b exp=0/0", occupancy, out_valid);
    end
  endtask

  task automatic model_step(input logic iv, input logic [7:0] id, input logic ordy,
                            input logic fl, input logic st);
    bit accept;
    int lim;
    if (fl) begin
      mpos.delete(); mdat.delete();
      return;
    end
    if (st) return;
    accept = iv && ((mpos.size() < STAGES) || ordy);
    if (mpos.size() > 0 && mpos[0] == STAGES - 1 && ordy) begin
      void'(mpos.pop_front()); void'(mdat.pop_front());
    end
    for (int k = 0; k < mpos.size(); k++) begin
      lim = (k == 0) ? STAGES : mpos[k-1];
      if (mpos[k] + 1 < lim) mpos[k] = mpos[k] + 1;
    end
    if (accept) begin
      mpos.push_back(0); mdat.push_back(id);
    end
  endtask

  task automatic test_random();
    logic iv, ordy, fl, st, e_ir, e_ov;
    logic [7:0] id;
    mpos.delete(); mdat.delete();
    clear();
    for (int c = 0; c < 400; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      id   = 8'($urandom);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      st   = ($urandom_range(0, 9) == 0);
      drive(iv, id, ordy, fl, st);
      e_ir = fl || (!st && ((mpos.size() < STAGES) || ordy));
      e_ov = !fl && !st && (mpos.size() > 0) && (mpos[0] == STAGES - 1);
      checks++; if (in_ready !== e_ir) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", c, in_ready, e_ir); end
      checks++; if (out_valid !== e_ov) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%0b exp=%0b", c, out_valid, e_ov); end
      checks++; if (occupancy !== 2'(mpos.size())) begin failures++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", c, occupancy, mpos.size()); end
      if (e_ov) begin
        checks++; if (out_data !== mdat[0]) begin failures++; $display("FAIL rnd_out_data cyc=%0d got=%h exp=%h", c, out_data, mdat[0]); end
      end
      model_step(iv, id, ordy, fl, st);
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; stall = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_stall_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
